// File: rtl/maze_nav_ctrl.sv
// Left-hand wall-following navigation FSM for the maze robot; one command per visit to DECIDE.
// Commands are registered Moore outputs and are applied by the map on the following edge; no backpressure.
module maze_nav_ctrl #(
    parameter int MAX_MOVES         = 255,
    parameter int MAX_REMOVE_CYCLES = 12,
    parameter int CNT_W             = 8
) (
    input  logic             selected_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             head_in,
    input  logic             left_in,
    input  logic             under_in,
    input  logic             barrier_in,
    output logic             avancar,
    output logic             girar,
    output logic             remover,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] move_count,
    output logic             done,
    output logic             fault
);

    localparam int               REM_W         = $clog2(MAX_REMOVE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LP_MOVE_LIMIT = CNT_W'(MAX_MOVES);
    localparam logic [REM_W-1:0] LP_REM_LAST   = REM_W'(MAX_REMOVE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SETTLE  = 4'd1,
        S_DECIDE  = 4'd2,
        S_TURN_L  = 4'd3,
        S_TURN_R  = 4'd4,
        S_ADVANCE = 4'd5,
        S_REMOVE  = 4'd6,
        S_DONE    = 4'd7,
        S_FAULT   = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_turn_cnt;
    logic [REM_W-1:0]   r_rem_cnt;
    logic               r_left_flag;
    logic [CNT_W-1:0]   r_move_cnt;
    logic               r_avancar;
    logic               r_girar;
    logic               r_remover;
    logic               r_done;
    logic               r_fault;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_next = S_SETTLE;
            S_SETTLE:  w_next = S_DECIDE;
            S_DECIDE: begin
                if (!enable)                                   w_next = S_IDLE;
                else if (under_in)                             w_next = S_DONE;
                else if (barrier_in)                           w_next = S_REMOVE;
                else if (!left_in && !r_left_flag)             w_next = S_TURN_L;
                else if (!head_in && r_move_cnt == LP_MOVE_LIMIT) w_next = S_FAULT;
                else if (!head_in)                             w_next = S_ADVANCE;
                else                                           w_next = S_TURN_R;
            end
            S_TURN_L:  w_next = S_SETTLE;
            S_TURN_R:  if (r_turn_cnt == 2'd2) w_next = S_SETTLE;
            S_ADVANCE: w_next = S_SETTLE;
            // One extra remover cycle can follow the barrier vanishing, since the clear is only seen here.
            S_REMOVE: begin
                if (!barrier_in)                     w_next = S_SETTLE;
                else if (r_rem_cnt == LP_REM_LAST)   w_next = S_FAULT;
            end
            S_DONE:    if (!enable) w_next = S_IDLE;
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge selected_clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_turn_cnt  <= 2'd0;
            r_rem_cnt   <= '0;
            r_left_flag <= 1'b0;
            r_move_cnt  <= '0;
            r_avancar   <= 1'b0;
            r_girar     <= 1'b0;
            r_remover   <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_avancar <= (w_next == S_ADVANCE);
            r_girar   <= (w_next == S_TURN_L) || (w_next == S_TURN_R);
            r_remover <= (w_next == S_REMOVE);
            r_done    <= (w_next == S_DONE);
            r_fault   <= (w_next == S_FAULT);

            case (r_state)
                S_DECIDE: begin
                    if (w_next == S_TURN_L)  r_left_flag <= 1'b1;
                    if (w_next == S_ADVANCE) r_left_flag <= 1'b0;
                    if (w_next == S_TURN_R)  r_turn_cnt  <= 2'd0;
                    if (w_next == S_REMOVE)  r_rem_cnt   <= '0;
                end
                S_TURN_R:  r_turn_cnt <= r_turn_cnt + 2'd1;
                S_ADVANCE: if (r_move_cnt != '1) r_move_cnt <= r_move_cnt + 1'b1;
                S_REMOVE: begin
                    if (w_next == S_REMOVE) r_rem_cnt <= r_rem_cnt + 1'b1;
                    else                    r_rem_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign state_out  = r_state;
    assign move_count = r_move_cnt;
    assign avancar    = r_avancar;
    assign girar      = r_girar;
    assign remover    = r_remover;
    assign done       = r_done;
    assign fault      = r_fault;

endmodule

// File: tb/tb_maze_nav_ctrl.sv
// Directed bench for maze_nav_ctrl with a plan-based reference model checked every cycle.
module tb_maze_nav_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable, head_in, left_in, under_in, barrier_in;
    logic       avancar, girar, remover, done, fault;
    logic [3:0] state_out;
    logic [7:0] move_count;

    int n_vec = 0;
    int n_err = 0;

    maze_nav_ctrl #(.MAX_MOVES(255), .MAX_REMOVE_CYCLES(12), .CNT_W(8)) dut (
        .selected_clock (clk),
        .reset          (rst),
        .enable         (enable),
        .head_in        (head_in),
        .left_in        (left_in),
        .under_in       (under_in),
        .barrier_in     (barrier_in),
        .avancar        (avancar),
        .girar          (girar),
        .remover        (remover),
        .state_out      (state_out),
        .move_count     (move_count),
        .done           (done),
        .fault          (fault)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the robot's expected state, advance count, and any queued multi-cycle plan.
    logic [3:0] e_st   = 4'd0;
    logic [7:0] m_move = 8'd0;
    logic [3:0] plan_q[$];
    bit         m_flag = 1'b0;
    int         m_rcnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_st = 4'd0;
            plan_q.delete();
            m_move = 8'd0;
            m_flag = 1'b0;
            m_rcnt = 0;
        end else begin
            if (e_st == 4'd5 && m_move != 8'd255) m_move = m_move + 8'd1;
            if (plan_q.size() > 0) begin
                e_st = plan_q.pop_front();
            end else begin
                case (e_st)
                    4'd0: e_st = enable ? 4'd1 : 4'd0;
                    4'd1: e_st = 4'd2;
                    4'd2: begin
                        if (!enable) e_st = 4'd0;
                        else if (under_in) e_st = 4'd7;
                        else if (barrier_in) begin e_st = 4'd6; m_rcnt = 1; end
                        else if (!left_in && !m_flag) begin e_st = 4'd3; m_flag = 1'b1; end
                        else if (!head_in && m_move == 8'd255) e_st = 4'd8;
                        else if (!head_in) begin e_st = 4'd5; m_flag = 1'b0; end
                        else begin
                            // a right turn is three left pulses, then settle
                            e_st = 4'd4;
                            plan_q.push_back(4'd4);
                            plan_q.push_back(4'd4);
                            plan_q.push_back(4'd1);
                        end
                    end
                    4'd3, 4'd5: e_st = 4'd1;
                    4'd6: begin
                        if (!barrier_in) e_st = 4'd1;
                        else if (m_rcnt == 12) e_st = 4'd8;
                        else m_rcnt = m_rcnt + 1;
                    end
                    4'd7: e_st = enable ? 4'd7 : 4'd0;
                    4'd8: e_st = 4'd8;
                    default: e_st = 4'd0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle_outputs",
            {15'd0, state_out, avancar, girar, remover, done, fault, move_count},
            {15'd0, e_st, e_st == 4'd5, (e_st == 4'd3) || (e_st == 4'd4), e_st == 4'd6,
             e_st == 4'd7, e_st == 4'd8, m_move});
    end

    task automatic do_reset();
        #2;
        rst = 1'b1;
        {enable, head_in, left_in, under_in, barrier_in} = 5'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int         n;
    bit         ok;
    bit         cmd;
    logic [3:0] exp4 [8] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd5, 4'd1, 4'd2};

    initial begin
        {enable, head_in, left_in, under_in, barrier_in} = 5'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_state", {19'd0, state_out, avancar, girar, remover, done, fault, move_count}, 32'd0);

        // Start on the goal cell
        @(negedge clk);
        rst = 1'b0; under_in = 1'b1; enable = 1'b1;
        cmd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cmd = cmd | avancar | girar | remover;
        end
        chk("goal_done", {20'd0, state_out, done, move_count}, {20'd0, 4'd7, 1'b1, 8'd0});
        chk("goal_no_cmd", 32'(cmd), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        chk("done_to_idle", {27'd0, state_out, done}, {27'd0, 4'd0, 1'b0});

        // Open corridor: advance until the move budget runs out
        under_in = 1'b0; head_in = 1'b0; left_in = 1'b1; enable = 1'b1;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (avancar) n++;
            if (fault) begin ok = 1'b1; break; end
        end
        chk("move_fault_reached", 32'(ok), 32'd1);
        chk("move_adv_pulses", 32'(n), 32'd255);
        chk("move_count_at_fault", 32'(move_count), 32'd255);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("fault_sticky", {27'd0, state_out, fault}, {27'd0, 4'd8, 1'b1});

        // Dead end ahead, wall left: right turn
        do_reset();
        head_in = 1'b1; left_in = 1'b1; enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (girar) begin ok = 1'b1; break; end
        end
        chk("turnr_start", 32'(ok), 32'd1);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (girar) n++;
            else break;
        end
        chk("turnr_pulses", 32'(n), 32'd3);
        chk("turnr_then_settle", 32'(state_out), 32'd1);

        // Open left and ahead: one left turn, then the flag forces an advance
        do_reset();
        head_in = 1'b0; left_in = 1'b0; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("turnl_seq", 32'(state_out), 32'(exp4[i]));
        end
        chk("turnl_move", 32'(move_count), 32'd1);

        // Barrier cleared after nine remover cycles, then a stuck barrier
        do_reset();
        barrier_in = 1'b1; head_in = 1'b1; left_in = 1'b1; enable = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (remover) n++;
            if (n == 9) break;
        end
        barrier_in = 1'b0;
        chk("rm_nine_seen", 32'(n), 32'd9);
        @(negedge clk);
        chk("rm_release", {27'd0, state_out, remover}, {27'd0, 4'd1, 1'b0});
        barrier_in = 1'b1;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (remover) n++;
            if (fault) begin ok = 1'b1; break; end
        end
        chk("rm_stuck_fault", 32'(ok), 32'd1);
        chk("rm_stuck_pulses", 32'(n), 32'd12);

        // Asynchronous reset in the middle of a right turn
        do_reset();
        head_in = 1'b0; left_in = 1'b1; enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (avancar) begin ok = 1'b1; break; end
        end
        chk("arst_adv_seen", 32'(ok), 32'd1);
        head_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (girar) begin ok = 1'b1; break; end
        end
        chk("arst_turn_seen", 32'(ok), 32'd1);
        @(negedge clk);
        chk("arst_second_pulse", {19'd0, state_out, girar, move_count}, {19'd0, 4'd4, 1'b1, 8'd1});
        #2 rst = 1'b1;
        #1 chk("arst_immediate", {19'd0, state_out, avancar, girar, remover, done, fault, move_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Enable dropped while deciding
        head_in = 1'b1; left_in = 1'b1; enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state_out == 4'd2) begin ok = 1'b1; break; end
        end
        chk("decide_seen", 32'(ok), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("decide_to_idle", 32'(state_out), 32'd0);
        cmd = 1'b0;
        repeat (5) begin
            @(negedge clk);
            cmd = cmd | avancar | girar | remover;
        end
        chk("idle_quiet", 32'(cmd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maze_nav_ctrl.md
Name: maze_nav_ctrl

Overview:
- Autonomous navigation controller for the maze robot.
- Reads the map block's four sensor bits (head, left, under, barrier) and sequences its three command inputs (advance, rotate, remove) to run a left-hand wall-following search.
- Stops when the robot stands on the black goal cell, or enters a fault state on a timeout.
- Runs on the same selected clock as the map, so every command is applied by the map on the edge after it is issued.

Parameters:
- MAX_MOVES, 255: advance commands allowed before FAULT.
- MAX_REMOVE_CYCLES, 12: consecutive remove cycles allowed on one barrier before FAULT.
- CNT_W, 8: width of move_count; must satisfy 2^CNT_W > MAX_MOVES.

Ports:
- selected_clock input 1: system clock, the same clock driving the map block.
- reset input 1: asynchronous, active-high.
- enable input 1: start/continue navigation.
- head_in input 1: wall or edge directly ahead.
- left_in input 1: wall or edge on the left.
- under_in input 1: robot is on the black goal cell.
- barrier_in input 1: barrier directly ahead.
- avancar input of map, driven here as output 1: advance command.
- girar output 1: rotate command; one pulse = 90 degrees counter-clockwise (left).
- remover output 1: remove command.
- state_out output 4: current FSM state encoding.
- move_count output CNT_W: number of advances issued since reset.
- done output 1: goal reached.
- fault output 1: timeout occurred.

Behaviour:
- Reset: state IDLE; all outputs 0; turn counter, remove counter and left-turn flag cleared.
- Outputs are registered Moore outputs. avancar, girar and remover are high exactly during the cycles spent in ADVANCE, TURN_L/TURN_R and REMOVE respectively. At most one command is high in any cycle.
- State encodings: IDLE=0, SETTLE=1, DECIDE=2, TURN_L=3, TURN_R=4, ADVANCE=5, REMOVE=6, DONE=7, FAULT=8.
- IDLE: enable=1 -> SETTLE; otherwise stay.
- SETTLE: lasts one cycle so the sensor bits reflect the map's update from the previous command. Always -> DECIDE.
- DECIDE: evaluated in the first matching priority order below.
  1. enable=0 -> IDLE.
  2. under_in=1 -> DONE.
  3. barrier_in=1 -> REMOVE.
  4. left_in=0 and left-turn flag=0 -> TURN_L; set the flag.
  5. head_in=0 and move_count==MAX_MOVES -> FAULT.
  6. head_in=0 -> ADVANCE; clear the flag.
  7. Otherwise -> TURN_R; turn counter = 0.
- TURN_L: one cycle with girar=1 -> SETTLE.
- TURN_R: girar=1 for 3 consecutive cycles (three left turns = one right turn). The turn counter goes 0..2; on 2 -> SETTLE. The left-turn flag is left unchanged.
- ADVANCE: one cycle with avancar=1; move_count increments (saturates at its maximum) -> SETTLE.
- REMOVE: remover=1; the remove counter increments each cycle.
  - barrier_in=0 sampled -> SETTLE and counter cleared; one overshoot remover cycle is permitted.
  - Counter reaches MAX_REMOVE_CYCLES-1 with barrier_in still 1 -> FAULT.
- DONE: done=1 and all commands 0. Held until reset, or until enable=0, which returns to IDLE with done cleared and move_count kept.
- FAULT: fault=1 and all commands 0. Held until reset only; enable is ignored.
- Mid-command behaviour:
  - enable is sampled only in IDLE, DECIDE and DONE, so TURN_R always completes all 3 pulses.
  - Asynchronous reset mid-command drops every command output immediately.
- Sensors are treated as valid only in DECIDE and REMOVE; values in other states are ignored.

Test Plan:
- Reset with robot at (9,0) facing north, map start cell black (under_in=1), enable=1 -> SETTLE, DECIDE, DONE within 3 cycles; done=1; move_count=0; no command pulse.
- head_in=0, left_in=1, barrier_in=0, under_in=0 held constant -> avancar pulse every 3 cycles; move_count reaches 255 and the next DECIDE enters FAULT, with fault=1 and no 256th avancar.
- head_in=1, left_in=1 -> girar high for exactly 3 consecutive cycles, then SETTLE; no avancar.
- left_in=0, head_in=0 -> one girar pulse (TURN_L), then ADVANCE on the next DECIDE even though left_in is still 0 (flag blocks a second left turn).
- barrier_in=1 cleared by the bench after 9 remover cycles -> remover high 9–10 cycles, then SETTLE. With barrier_in stuck at 1 -> FAULT after 12 remover cycles.
- Assert reset during the second TURN_R cycle -> girar=0 immediately, state_out=0, move_count=0. Drop enable in DECIDE -> IDLE with no further commands.
